// File: rtl/nmr_echo_acq_sequencer.sv
// CPMG scan acquisition sequencer: gates ADC samples into the acquisition FIFO
// one echo window at a time and reports scan status to the host.
module nmr_echo_acq_sequencer #(
  parameter int ADC_W = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] samples_per_echo,
  input  logic [CNT_W-1:0] echoes_per_scan,
  input  logic             echo_trig,
  input  logic             adc_valid,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             fifo_full,
  output logic             fifo_wr,
  output logic [ADC_W:0]   fifo_data,
  output logic             busy,
  output logic             acq_active,
  output logic             done,
  output logic             overflow,
  output logic             missed_trig,
  output logic             cfg_err,
  output logic [CNT_W-1:0] echo_idx
);

  // Handshake: adc_valid is a pure strobe with no back-pressure. fifo_full never
  // stalls the ADC; a sample seen while full is dropped (and flagged), and
  // fifo_wr is a single-cycle write strobe with fifo_data valid in that cycle.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    ACQ   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   spe_q, spe_d;
  logic [CNT_W-1:0]   eps_q, eps_d;
  logic [CNT_W-1:0]   scnt_q, scnt_d;
  logic [CNT_W-1:0]   echo_q, echo_d;
  logic               ovf_q, ovf_d;
  logic               miss_q, miss_d;
  logic               cfg_q, cfg_d;
  logic               wr_q, wr_d;
  logic [ADC_W:0]     wdata_q, wdata_d;
  logic               last_sample;
  logic [CNT_W-1:0]   echo_inc;

  assign last_sample = (scnt_q == (spe_q - ONE));
  assign echo_inc    = echo_q + ONE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      spe_q   <= '0;
      eps_q   <= '0;
      scnt_q  <= '0;
      echo_q  <= '0;
      ovf_q   <= 1'b0;
      miss_q  <= 1'b0;
      cfg_q   <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      spe_q   <= spe_d;
      eps_q   <= eps_d;
      scnt_q  <= scnt_d;
      echo_q  <= echo_d;
      ovf_q   <= ovf_d;
      miss_q  <= miss_d;
      cfg_q   <= cfg_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    spe_d   = spe_q;
    eps_d   = eps_q;
    scnt_d  = scnt_q;
    echo_d  = echo_q;
    ovf_d   = ovf_q;
    miss_d  = miss_q;
    cfg_d   = cfg_q;
    wr_d    = 1'b0;
    wdata_d = wdata_q;

    // Abort wins over everything else in the cycle, including a sample write.
    if (state_q != IDLE && abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (samples_per_echo == '0 || echoes_per_scan == '0) begin
              cfg_d = 1'b1;
            end else begin
              spe_d   = samples_per_echo;
              eps_d   = echoes_per_scan;
              echo_d  = '0;
              ovf_d   = 1'b0;
              miss_d  = 1'b0;
              cfg_d   = 1'b0;
              state_d = ARMED;
            end
          end
        end
        ARMED: begin
          if (echo_trig) begin
            scnt_d  = '0;
            state_d = ACQ;
          end
        end
        ACQ: begin
          if (echo_trig) miss_d = 1'b1;
          if (adc_valid) begin
            if (fifo_full) begin
              ovf_d = 1'b1;
            end else begin
              wr_d    = 1'b1;
              wdata_d = {last_sample, adc_data};
            end
            // Dropped samples still count so the window length stays fixed.
            if (last_sample) begin
              echo_d  = echo_inc;
              scnt_d  = '0;
              state_d = (echo_inc == eps_q) ? DONE : ARMED;
            end else begin
              scnt_d = scnt_q + ONE;
            end
          end
        end
        DONE: begin
          if (echo_trig) miss_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign fifo_wr     = wr_q;
  assign fifo_data   = wdata_q;
  assign busy        = (state_q != IDLE);
  assign acq_active  = (state_q == ACQ);
  assign done        = (state_q == DONE);
  assign overflow    = ovf_q;
  assign missed_trig = miss_q;
  assign cfg_err     = cfg_q;
  assign echo_idx    = echo_q;

endmodule

// File: doc/nmr_echo_acq_sequencer.md
Name: nmr_echo_acq_sequencer

Overview:
- Sequences ADC sample capture for one CPMG scan.
- Latches the host-programmed samples_per_echo and echoes_per_scan parameter registers on start.
- For each echo trigger from the pulse programmer, forwards exactly samples_per_echo ADC samples into the acquisition FIFO, tagging the last sample of each echo.
- Sits between the Avalon PIO parameter registers and the ADC/FIFO datapath; reports status back to HPS-readable PIOs.

Parameters:
- ADC_W, 16, ADC sample width in bits.
- CNT_W, 32, width of the sample and echo counters; matches the parameter register width.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  reset.
- start  input  1  one-cycle pulse; arms a scan when IDLE.
- abort  input  1  one-cycle pulse; terminates the scan.
- samples_per_echo  input  CNT_W  samples per echo window (PIO out_port).
- echoes_per_scan  input  CNT_W  echo windows per scan.
- echo_trig  input  1  one-cycle pulse marking the start of an acquisition window.
- adc_valid  input  1  ADC sample strobe.
- adc_data  input  ADC_W  ADC sample.
- fifo_full  input  1  acquisition FIFO full.
- fifo_wr  output  1  FIFO write strobe.
- fifo_data  output  ADC_W+1  {last_of_echo, sample}.
- busy  output  1  high from start acceptance until return to IDLE.
- acq_active  output  1  high while in ACQ.
- done  output  1  one-cycle pulse on normal completion.
- overflow  output  1  sticky: a sample was dropped on FIFO full.
- missed_trig  output  1  sticky: echo_trig arrived outside ARMED.
- cfg_err  output  1  sticky: start received with a zero parameter.
- echo_idx  output  CNT_W  echoes completed in the current scan.

Behaviour:
- Reset is asynchronous, active-low on reset_n, clocked on clk.
- All outputs reset to 0; state resets to IDLE.
- States: IDLE, ARMED, ACQ, DONE.

IDLE:
- start with both parameters nonzero: latch both parameters, clear echo_idx, overflow, missed_trig and cfg_err, then go to ARMED next cycle.
- start with either parameter zero: set cfg_err, stay IDLE, no done pulse.

ARMED:
- echo_trig moves to ACQ next cycle and clears the sample counter.
- adc_valid is ignored in ARMED.

ACQ:
- Each adc_valid increments the sample counter.
- If fifo_full is low, register fifo_wr=1 and fifo_data next cycle (latency 1).
- If fifo_full is high, drop the sample, set overflow, and still count it so window timing is preserved.
- The sample with count == samples_per_echo−1 gets last_of_echo=1 and increments echo_idx.
- After that sample: if echo_idx reaches echoes_per_scan, go to DONE; otherwise go to ARMED.

DONE:
- Pulse done for one cycle, then return to IDLE.

Other rules:
- echo_trig in ACQ, DONE or IDLE-while-busy sets missed_trig and is otherwise ignored.
- An echo_trig in the same cycle as the final sample of a window is counted as missed.
- start while busy is ignored.
- abort in any non-IDLE state returns to IDLE next cycle, with no done pulse and no further fifo_wr. A write already registered in that cycle still completes.
- Parameter inputs changing mid-scan have no effect; only latched copies are used.
- Counters are CNT_W wide with no wrap in legal operation (max 2^32−1).
- busy drops the cycle DONE/abort returns to IDLE.
- acq_active equals (state == ACQ).

Test Plan:
- samples_per_echo=4, echoes_per_scan=3, three echo_trigs, each followed by 4 adc_valid (data 0x0010..0x0013), fifo_full=0 -> 12 fifo_wr; last_of_echo set on writes 4, 8 and 12; echo_idx steps 1→2→3; single done pulse; busy low after.
- Same config with fifo_full=1 during sample 2 of echo 2 -> 11 writes; overflow=1; echo window still ends after 4 samples; done still pulses.
- samples_per_echo=0, start -> cfg_err=1, busy stays 0, no fifo_wr.
- samples_per_echo=8, 2 echoes; abort after sample 3 of echo 1 -> IDLE next cycle, no done, echo_idx=0, no writes after the abort cycle.
- echo_trig pulsed during ACQ of echo 1 (spe=5, eps=2) -> missed_trig=1, current window unaffected; scan completes only after a second valid trig in ARMED.
- reset_n asserted mid-ACQ, then released, then start with spe=2, eps=1 -> all outputs 0 during reset; fresh scan gives 2 writes and done.
